targeting_sequencer: RTL and testbench
======================================

# targeting_sequencer

Parametrised next-generation trench-run targeting FSM. It watches a coded sensor stream for the lock sequence: an exactly-N-cycle sync run, then a two-step gate, then an M-cycle core window. When enough core signatures land inside the window, it issues a one-cycle `proton_fire` pulse. Over the fixed-width first-generation sequencer it adds:
- configurable codes and lengths
- an arm enable
- an abort indication
- a post-fire cooldown
- an optional shot counter

It sits between the sensor front end and the torpedo release logic.

## Interface
- `SENS_W`, 3: sensor code width.
- `SYNC_CODE`, 7: calibration sync code.
- `SYNC_LEN`, 2: required consecutive sync samples (exactly); ≥1.
- `GATE_A`, 1: first gate code.
- `GATE_B`, 2: second gate code.
- `CORE_CODE`, 4: core signature code.
- `ABORT_CODE`, 5: enemy-lock abort code.
- `WINDOW_LEN`, 4: window length in samples; ≥1.
- `CORE_HITS`, 2: cores needed to fire; 1..`WINDOW_LEN`.
- `COOLDOWN`, 0: cycles inputs are ignored after a fire; 0 disables.
- All codes are distinct.
- `clk`  in  1: single clock; all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `sensor_in`  in  `SENS_W`: one code sampled every cycle.
- `arm_en`  in  1: low forces `IDLE` at the next edge.
- `proton_fire`  out  1: registered one-cycle fire pulse.
- `abort_flag`  out  1: registered one-cycle pulse on abort.
- `state_o`  out  3: current state encoding.
- `shot_count`  out  8: saturating fire count.

## Operation
States, with `state_o` encoding:
- `IDLE`=0, `SYNC`=1, `GATE`=2, `WINDOW`=3, `COOL`=4.
- Counters: `sync_cnt` saturates at `SYNC_LEN`+1; window position `t` runs 1..`WINDOW_LEN`; `hit_cnt` counts cores.

Transitions:
- **`IDLE`**:
  - `SYNC_CODE` → `SYNC`, `sync_cnt`=1.
  - Anything else stays in `IDLE`.
- **`SYNC`**:
  - `SYNC_CODE` → increment `sync_cnt` (saturating).
  - `GATE_A` with `sync_cnt`==`SYNC_LEN` → `GATE`.
  - Any other code → `IDLE`. This includes `GATE_A` after a short or long run (the exactly-N rule).
- **`GATE`**:
  - `GATE_B` → `WINDOW`, `t`=0, `hit_cnt`=0.
  - `ABORT_CODE` → `IDLE` with `abort_flag`.
  - `SYNC_CODE` → `SYNC`, `sync_cnt`=1.
  - Else → `IDLE`.
- **`WINDOW`**, each sample increments `t`:
  - `CORE_CODE` increments `hit_cnt`.
  - `ABORT_CODE` → `IDLE` with `abort_flag`. Abort has priority over everything.
  - When `hit_cnt` reaches `CORE_HITS` → fire. Next state is `COOL` if `COOLDOWN`>0, else `IDLE`.
  - When `t`==`WINDOW_LEN` without reaching `CORE_HITS` → `IDLE`, silently.
  - Other codes, including `SYNC_CODE`, are noise and change nothing.
- **`COOL`**:
  - Ignores `sensor_in` for `COOLDOWN` cycles, then → `IDLE`.
  - Abort is not checked.

Priority and counting rules:
- `arm_en` low overrides every transition: next state `IDLE` with all counters cleared. No `proton_fire` or `abort_flag` is generated in that cycle.
- `rst` overrides `arm_en`.
- `shot_count` increments on each fire and saturates at 255.

## Timing
- Reset values: `proton_fire`=0, `abort_flag`=0, `state_o`=0 (`IDLE`), `shot_count`=0, all counters 0.
- `rst` asserted mid-sequence returns everything to these values at the next edge.
- `proton_fire` is high for exactly the one cycle following the edge that sampled the `CORE_HITS`-th core.
- `abort_flag` is high for the one cycle following the edge that sampled `ABORT_CODE`.
- `state_o` reflects the state after each edge.
- Default-parameter fire latency: 8 samples after the first sync.
  - The sequence is `7,7,1,2,x,4,x,4`.
  - `proton_fire` is visible after the 8th edge.
- With `COOLDOWN`=0, the sample after the fire edge is evaluated from `IDLE`.
- A `SYNC_CODE` on that sample starts a new run.
- Every sample is consumed on one edge; there is no back-pressure.

## Configuration
- `TARGETING_SHOT_COUNT_EN` defined: the 8-bit saturating `shot_count` register is built.
- Not defined: `shot_count` is tied to 0 and no counter logic is synthesised. The FSM is otherwise identical.

## Test plan
- **Defaults:** `0,7,7,1,2,0,4,0,4,0`.
  - `proton_fire`=1 only in the cycle after the 2nd `4`.
  - `state_o` returns to 0.
  - `shot_count`=1.
- **Abort:** `7,7,1,2,4,5,4`.
  - `abort_flag` pulses after the `5`.
  - `proton_fire` stays 0.
  - `state_o`=0.
- **Noise:** `7,7,7,1,2,4,4` → no fire; `state_o`=0 after the `1`.
- **Short run:** `7,1,2,4,4` → no fire.
- **Window expiry and arm:** `WINDOW_LEN`=4, `CORE_HITS`=3, stream `7,7,1,2,4,0,4,0`.
  - No fire; `state_o`=0 after the 4th window sample.
  - Repeat a valid defaults sequence with `arm_en` dropped mid-window → no fire, `state_o`=0.
- **Cooldown:** `COOLDOWN`=3.
  - A valid sequence fires.
  - An immediately following `7,7,1,2,4,0,4` is partly swallowed by `COOL` → no second fire.
  - The same sequence sent after 3 idle cycles fires; `shot_count`=2.

Source files
------------

// File: rtl/targeting_sequencer.sv
// Lock-sequence FSM (sync run, two-step gate, core window) issuing a one-cycle proton_fire pulse; shot counter built under TARGETING_SHOT_COUNT_EN.
// Outputs registered one edge after the deciding sample; one sample consumed per cycle, no back-pressure.
module targeting_sequencer #(
  parameter int unsigned SENS_W     = 3,
  parameter int unsigned SYNC_CODE  = 7,
  parameter int unsigned SYNC_LEN   = 2,
  parameter int unsigned GATE_A     = 1,
  parameter int unsigned GATE_B     = 2,
  parameter int unsigned CORE_CODE  = 4,
  parameter int unsigned ABORT_CODE = 5,
  parameter int unsigned WINDOW_LEN = 4,
  parameter int unsigned CORE_HITS  = 2,
  parameter int unsigned COOLDOWN   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SENS_W-1:0] sensor_in,
  input  logic              arm_en,
  output logic              proton_fire,
  output logic              abort_flag,
  output logic [2:0]        state_o,
  output logic [7:0]        shot_count
);

  localparam int unsigned SC_W = $clog2(SYNC_LEN + 2);
  localparam int unsigned T_W  = $clog2(WINDOW_LEN + 1);
  localparam int unsigned H_W  = $clog2(CORE_HITS + 1);
  localparam int unsigned CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic [SC_W-1:0]   SYNC_LEN_C = SC_W'(SYNC_LEN);
  localparam logic [SC_W-1:0]   SYNC_SAT_C = SC_W'(SYNC_LEN + 1);
  localparam logic [T_W-1:0]    T_LAST_C   = T_W'(WINDOW_LEN);
  localparam logic [H_W-1:0]    HITS_C     = H_W'(CORE_HITS);
  localparam logic [CD_W-1:0]   CD_LAST_C  = CD_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam logic [SENS_W-1:0] SYNC_C     = SENS_W'(SYNC_CODE);
  localparam logic [SENS_W-1:0] GATE_A_C   = SENS_W'(GATE_A);
  localparam logic [SENS_W-1:0] GATE_B_C   = SENS_W'(GATE_B);
  localparam logic [SENS_W-1:0] CORE_C     = SENS_W'(CORE_CODE);
  localparam logic [SENS_W-1:0] ABORT_C    = SENS_W'(ABORT_CODE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    GATE   = 3'd2,
    WINDOW = 3'd3,
    COOL   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [SC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [T_W-1:0]  t_q, t_d, t_n;
  logic [H_W-1:0]  hit_cnt_q, hit_cnt_d, hit_n;
  logic [CD_W-1:0] cool_cnt_q, cool_cnt_d;
  logic            fire_q, fire_d;
  logic            abort_q, abort_d;

  logic is_sync, is_gate_a, is_gate_b, is_core, is_abort;

  assign is_sync   = (sensor_in == SYNC_C);
  assign is_gate_a = (sensor_in == GATE_A_C);
  assign is_gate_b = (sensor_in == GATE_B_C);
  assign is_core   = (sensor_in == CORE_C);
  assign is_abort  = (sensor_in == ABORT_C);

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    t_d        = t_q;
    hit_cnt_d  = hit_cnt_q;
    cool_cnt_d = cool_cnt_q;
    fire_d     = 1'b0;
    abort_d    = 1'b0;
    t_n        = t_q + 1'b1;
    hit_n      = hit_cnt_q + H_W'(is_core);

    if (!arm_en) begin
      state_d    = IDLE;
      sync_cnt_d = '0;
      t_d        = '0;
      hit_cnt_d  = '0;
      cool_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_sync) begin
            state_d    = SYNC;
            sync_cnt_d = SC_W'(1);
          end
        end

        SYNC: begin
          if (is_sync) begin
            if (sync_cnt_q != SYNC_SAT_C) sync_cnt_d = sync_cnt_q + 1'b1;
          end else if (is_gate_a && (sync_cnt_q == SYNC_LEN_C)) begin
            state_d    = GATE;
            sync_cnt_d = '0;
          end else begin
            // A short or over-long run followed by GATE_A also lands here.
            state_d    = IDLE;
            sync_cnt_d = '0;
          end
        end

        GATE: begin
          if (is_gate_b) begin
            state_d   = WINDOW;
            t_d       = '0;
            hit_cnt_d = '0;
          end else if (is_abort) begin
            state_d = IDLE;
            abort_d = 1'b1;
          end else if (is_sync) begin
            state_d    = SYNC;
            sync_cnt_d = SC_W'(1);
          end else begin
            state_d = IDLE;
          end
        end

        WINDOW: begin
          if (is_abort) begin
            state_d   = IDLE;
            abort_d   = 1'b1;
            t_d       = '0;
            hit_cnt_d = '0;
          end else if (hit_n == HITS_C) begin
            // A hit on the last window sample still fires.
            fire_d     = 1'b1;
            state_d    = (COOLDOWN > 0) ? COOL : IDLE;
            t_d        = '0;
            hit_cnt_d  = '0;
            cool_cnt_d = '0;
          end else if (t_n == T_LAST_C) begin
            state_d   = IDLE;
            t_d       = '0;
            hit_cnt_d = '0;
          end else begin
            t_d       = t_n;
            hit_cnt_d = hit_n;
          end
        end

        COOL: begin
          if (cool_cnt_q == CD_LAST_C) begin
            state_d    = IDLE;
            cool_cnt_d = '0;
          end else begin
            cool_cnt_d = cool_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_cnt_q <= '0;
      t_q        <= '0;
      hit_cnt_q  <= '0;
      cool_cnt_q <= '0;
      fire_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      t_q        <= t_d;
      hit_cnt_q  <= hit_cnt_d;
      cool_cnt_q <= cool_cnt_d;
      fire_q     <= fire_d;
      abort_q    <= abort_d;
    end
  end

  assign proton_fire = fire_q;
  assign abort_flag  = abort_q;
  assign state_o     = state_q;

`ifdef TARGETING_SHOT_COUNT_EN
  logic [7:0] shot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shot_q <= '0;
    end else if (fire_d && (shot_q != 8'hFF)) begin
      shot_q <= shot_q + 8'd1;
    end
  end

  assign shot_count = shot_q;
`else
  assign shot_count = '0;
`endif

endmodule

// File: tb/tb_targeting_sequencer.sv
// Directed bench for targeting_sequencer: default, CORE_HITS=3 and COOLDOWN=3 instances.
module tb_targeting_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] sens   [3];
  logic       arm    [3];
  logic       fire_w [3];
  logic       abort_w[3];
  logic [2:0] st_w   [3];
  logic [7:0] shot_w [3];

  int    compared;
  int    mismatched;
  int    n_step;
  string phase;

  typedef struct {
    int         d;
    logic       f;
    logic       a;
    logic [2:0] s;
  } exp_t;

  exp_t sb[$];

  targeting_sequencer u_def (
    .clk(clk), .rst(rst), .sensor_in(sens[0]), .arm_en(arm[0]),
    .proton_fire(fire_w[0]), .abort_flag(abort_w[0]), .state_o(st_w[0]), .shot_count(shot_w[0])
  );

  targeting_sequencer #(.CORE_HITS(3)) u_hit3 (
    .clk(clk), .rst(rst), .sensor_in(sens[1]), .arm_en(arm[1]),
    .proton_fire(fire_w[1]), .abort_flag(abort_w[1]), .state_o(st_w[1]), .shot_count(shot_w[1])
  );

  targeting_sequencer #(.COOLDOWN(3)) u_cool (
    .clk(clk), .rst(rst), .sensor_in(sens[2]), .arm_en(arm[2]),
    .proton_fire(fire_w[2]), .abort_flag(abort_w[2]), .state_o(st_w[2]), .shot_count(shot_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] shots(input int n);
`ifdef TARGETING_SHOT_COUNT_EN
    return 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one sample into instance d, queue its expected outputs, then compare after the edge.
  task automatic step(input int d, input logic [2:0] c, input logic a,
                      input logic ef, input logic ea, input logic [2:0] es);
    exp_t e;
    e.d = d; e.f = ef; e.a = ea; e.s = es;
    sens[d] = c;
    arm[d]  = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("%s[%0d] fire", phase, n_step), {7'd0, fire_w[e.d]}, {7'd0, e.f});
    check($sformatf("%s[%0d] abort", phase, n_step), {7'd0, abort_w[e.d]}, {7'd0, e.a});
    check($sformatf("%s[%0d] state", phase, n_step), {5'd0, st_w[e.d]}, {5'd0, e.s});
    n_step++;
    sens[d] = 3'd0;
    arm[d]  = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    n_step     = 0;
    for (int i = 0; i < 3; i++) begin
      sens[i] = 3'd0;
      arm[i]  = 1'b1;
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset fire %0d", i), {7'd0, fire_w[i]}, 8'd0);
      check($sformatf("reset abort %0d", i), {7'd0, abort_w[i]}, 8'd0);
      check($sformatf("reset state %0d", i), {5'd0, st_w[i]}, 8'd0);
      check($sformatf("reset shot %0d", i), shot_w[i], 8'd0);
    end
    rst = 1'b0;

    phase = "defaults";
    step(0, 0, 1, 0, 0, 0);
    step(0, 7, 1, 0, 0, 1);
    step(0, 7, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 2);
    step(0, 2, 1, 0, 0, 3);
    step(0, 0, 1, 0, 0, 3);
    step(0, 4, 1, 0, 0, 3);
    step(0, 0, 1, 0, 0, 3);
    step(0, 4, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("defaults shot", shot_w[0], shots(1));

    phase = "abort";
    step(0, 7, 1, 0, 0, 1);
    step(0, 7, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 2);
    step(0, 2, 1, 0, 0, 3);
    step(0, 4, 1, 0, 0, 3);
    step(0, 5, 1, 0, 1, 0);
    step(0, 4, 1, 0, 0, 0);

    phase = "noise_long_run";
    step(0, 7, 1, 0, 0, 1);
    step(0, 7, 1, 0, 0, 1);
    step(0, 7, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0);
    step(0, 2, 1, 0, 0, 0);
    step(0, 4, 1, 0, 0, 0);
    step(0, 4, 1, 0, 0, 0);

    phase = "short_run";
    step(0, 7, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0);
    step(0, 2, 1, 0, 0, 0);
    step(0, 4, 1, 0, 0, 0);
    step(0, 4, 1, 0, 0, 0);

    phase = "gate_abort";
    step(0, 7, 1, 0, 0, 1);
    step(0, 7, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 2);
    step(0, 5, 1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);

    phase = "gate_other";
    step(0, 7, 1, 0, 0, 1);
    step(0, 7, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 2);
    step(0, 4, 1, 0, 0, 0);

    phase = "gate_resync_backtoback";
    step(0, 7, 1, 0, 0, 1);
    step(0, 7, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 2);
    step(0, 7, 1, 0, 0, 1);
    step(0, 7, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 2);
    step(0, 2, 1, 0, 0, 3);
    step(0, 4, 1, 0, 0, 3);
    step(0, 4, 1, 1, 0, 0);
    step(0, 7, 1, 0, 0, 1);
    step(0, 7, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 2);
    step(0, 2, 1, 0, 0, 3);
    step(0, 4, 1, 0, 0, 3);
    step(0, 4, 1, 1, 0, 0);
    check("backtoback shot", shot_w[0], shots(3));

    phase = "sync_noise_in_window";
    step(0, 7, 1, 0, 0, 1);
    step(0, 7, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 2);
    step(0, 2, 1, 0, 0, 3);
    step(0, 7, 1, 0, 0, 3);
    step(0, 4, 1, 0, 0, 3);
    step(0, 7, 1, 0, 0, 3);
    step(0, 4, 1, 1, 0, 0);
    check("noise window shot", shot_w[0], shots(4));

    phase = "arm_drop";
    step(0, 7, 1, 0, 0, 1);
    step(0, 7, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 2);
    step(0, 2, 1, 0, 0, 3);
    step(0, 4, 1, 0, 0, 3);
    step(0, 4, 0, 0, 0, 0);
    step(0, 4, 1, 0, 0, 0);
    step(0, 7, 0, 0, 0, 0);
    step(0, 7, 1, 0, 0, 1);
    step(0, 5, 0, 0, 0, 0);
    check("arm_drop shot", shot_w[0], shots(4));

    phase = "mid_reset";
    step(0, 7, 1, 0, 0, 1);
    step(0, 7, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 2);
    rst = 1'b1;
    sens[0] = 3'd2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_reset state", {5'd0, st_w[0]}, 8'd0);
    check("mid_reset fire", {7'd0, fire_w[0]}, 8'd0);
    check("mid_reset shot", shot_w[0], 8'd0);
    step(0, 4, 1, 0, 0, 0);

    phase = "expiry_hits3";
    step(1, 7, 1, 0, 0, 1);
    step(1, 7, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 2);
    step(1, 2, 1, 0, 0, 3);
    step(1, 4, 1, 0, 0, 3);
    step(1, 0, 1, 0, 0, 3);
    step(1, 4, 1, 0, 0, 3);
    step(1, 0, 1, 0, 0, 0);
    step(1, 4, 1, 0, 0, 0);
    phase = "fire_hits3";
    step(1, 7, 1, 0, 0, 1);
    step(1, 7, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 2);
    step(1, 2, 1, 0, 0, 3);
    step(1, 4, 1, 0, 0, 3);
    step(1, 4, 1, 0, 0, 3);
    step(1, 4, 1, 1, 0, 0);
    check("hits3 shot", shot_w[1], shots(1));

    phase = "cooldown_fire";
    step(2, 7, 1, 0, 0, 1);
    step(2, 7, 1, 0, 0, 1);
    step(2, 1, 1, 0, 0, 2);
    step(2, 2, 1, 0, 0, 3);
    step(2, 0, 1, 0, 0, 3);
    step(2, 4, 1, 0, 0, 3);
    step(2, 0, 1, 0, 0, 3);
    step(2, 4, 1, 1, 0, 4);
    phase = "cooldown_swallow";
    step(2, 7, 1, 0, 0, 4);
    step(2, 7, 1, 0, 0, 4);
    step(2, 1, 1, 0, 0, 0);
    step(2, 2, 1, 0, 0, 0);
    step(2, 4, 1, 0, 0, 0);
    step(2, 0, 1, 0, 0, 0);
    step(2, 4, 1, 0, 0, 0);
    phase = "cooldown_refire";
    step(2, 0, 1, 0, 0, 0);
    step(2, 0, 1, 0, 0, 0);
    step(2, 0, 1, 0, 0, 0);
    step(2, 7, 1, 0, 0, 1);
    step(2, 7, 1, 0, 0, 1);
    step(2, 1, 1, 0, 0, 2);
    step(2, 2, 1, 0, 0, 3);
    step(2, 0, 1, 0, 0, 3);
    step(2, 4, 1, 0, 0, 3);
    step(2, 0, 1, 0, 0, 3);
    step(2, 4, 1, 1, 0, 4);
    step(2, 5, 1, 0, 0, 4);
    step(2, 0, 1, 0, 0, 4);
    step(2, 0, 1, 0, 0, 0);
    check("cooldown shot", shot_w[2], shots(2));

    check("scoreboard drained", 8'(sb.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
